// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT command sequencer: core opcodes, FSM states
// and job classification.
package ntt_pkg;

    localparam logic [4:0] OP_LD_PARAM = 5'b00001;
    localparam logic [4:0] OP_LD_W     = 5'b00010;
    localparam logic [4:0] OP_LD_DATA  = 5'b00011;
    localparam logic [4:0] OP_NTT      = 5'b00100;
    localparam logic [4:0] OP_INTT     = 5'b00111;
    localparam logic [4:0] OP_READ_INV = 5'b01000;
    localparam logic [4:0] OP_PWM      = 5'b01010;
    localparam logic [4:0] OP_READ     = 5'b01011;

    localparam int PARAM_WORDS = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_WAIT,
        ST_DRAIN,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        JOB_LOAD,
        JOB_COMPUTE,
        JOB_DRAIN,
        JOB_ILLEGAL
    } job_cls_e;

    function automatic job_cls_e op_class(input logic [4:0] op);
        case (op)
            OP_LD_PARAM, OP_LD_W, OP_LD_DATA: return JOB_LOAD;
            OP_NTT, OP_INTT, OP_PWM:          return JOB_COMPUTE;
            OP_READ_INV, OP_READ:             return JOB_DRAIN;
            default:                          return JOB_ILLEGAL;
        endcase
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ntt_seq_counter.sv
// Loadable, saturating down-counter shared by the word, drain and timeout counts.
module ntt_seq_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);
    assign one_o  = (count_q == W'(1));

endmodule

// File: rtl/ntt_cmd_sequencer.sv
// Job-level front end for the NTT core: issues the opcode pulse, streams load
// words from a valid/ready source, then waits for done or runs a drain window.
module ntt_cmd_sequencer
    import ntt_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int OPC_W     = 5,
    parameter int MAX_DEPTH = 12,
    parameter int POLY_CNT  = 2,
    parameter int TW_W      = 13,
    parameter int DRAIN_W   = 12,
    parameter int TIMEOUT   = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OPC_W-1:0]   cmd_op,
    input  logic [3:0]         cfg_ring_depth,
    input  logic [TW_W-1:0]    cfg_tw_words,
    input  logic [DRAIN_W-1:0] cfg_drain_len,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    output logic [OPC_W-1:0]   core_op_code,
    output logic               core_din_valid,
    output logic [DATA_W-1:0]  core_din0,
    input  logic               core_done,
    output logic               busy,
    output logic               job_done,
    output logic               err
);

    localparam int WORD_W = MAX_DEPTH + $clog2(POLY_CNT) + 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int CNT_W  = max_int(max_int(WORD_W, TW_W), max_int(DRAIN_W, TO_W));
    localparam logic [3:0] MAX_DEPTH_L = 4'(MAX_DEPTH);

    state_e             state_q;
    job_cls_e           job_cls_q;
    logic [OPC_W-1:0]   op_code_q;
    logic               cmd_ready_q;
    logic               busy_q;
    logic               s_ready_q;
    logic               drain_vld_q;
    logic               job_done_q;
    logic               err_q;

    logic               hi_zero;
    job_cls_e           cls;
    logic [3:0]         depth_eff;
    logic [CNT_W-1:0]   job_words;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               cnt_one;
    logic               load_hs;

    // Opcode bits above the 5-bit core encoding must be zero for a legal job.
    generate
        if (OPC_W > 5) begin : g_hi_bits
            assign hi_zero = (cmd_op[OPC_W-1:5] == '0);
        end else begin : g_no_hi_bits
            assign hi_zero = 1'b1;
        end
    endgenerate

    assign cls       = hi_zero ? op_class(cmd_op[4:0]) : JOB_ILLEGAL;
    assign depth_eff = (cfg_ring_depth > MAX_DEPTH_L) ? MAX_DEPTH_L : cfg_ring_depth;

    always_comb begin
        case (cmd_op[4:0])
            OP_LD_PARAM: job_words = CNT_W'(PARAM_WORDS);
            OP_LD_W:     job_words = CNT_W'(cfg_tw_words);
            default:     job_words = CNT_W'(POLY_CNT) << depth_eff;
        endcase
    end

    // Only one count is live per job, so a single counter serves all three.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_load = cmd_valid;
                case (cls)
                    JOB_LOAD:    cnt_val = job_words;
                    JOB_COMPUTE: cnt_val = CNT_W'(TIMEOUT);
                    JOB_DRAIN:   cnt_val = CNT_W'(cfg_drain_len);
                    default:     cnt_val = '0;
                endcase
            end
            ST_ISSUE: cnt_dec = (job_cls_q == JOB_DRAIN);
            ST_LOAD:  cnt_dec = s_valid;
            ST_WAIT:  cnt_dec = !core_done;
            ST_DRAIN: cnt_dec = 1'b1;
            default:  cnt_dec = 1'b0;
        endcase
    end

    ntt_seq_counter #(
        .W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            job_cls_q   <= JOB_ILLEGAL;
            op_code_q   <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            drain_vld_q <= 1'b0;
            job_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            job_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cls == JOB_ILLEGAL) begin
                            err_q      <= 1'b1;
                            job_done_q <= 1'b1;
                        end else begin
                            state_q     <= ST_ISSUE;
                            job_cls_q   <= cls;
                            op_code_q   <= cmd_op;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            drain_vld_q <= (cls == JOB_DRAIN);
                        end
                    end
                end
                ST_ISSUE: begin
                    op_code_q <= '0;
                    case (job_cls_q)
                        JOB_LOAD: begin
                            if (cnt_zero) begin
                                state_q    <= ST_GAP;
                                job_done_q <= 1'b1;
                            end else begin
                                state_q   <= ST_LOAD;
                                s_ready_q <= 1'b1;
                            end
                        end
                        JOB_COMPUTE: state_q <= ST_WAIT;
                        JOB_DRAIN: begin
                            // The issue cycle already counts as one drain cycle.
                            if (cnt_zero || cnt_one) begin
                                state_q     <= ST_GAP;
                                job_done_q  <= 1'b1;
                                drain_vld_q <= 1'b0;
                            end else begin
                                state_q <= ST_DRAIN;
                            end
                        end
                        default: begin
                            state_q    <= ST_GAP;
                            job_done_q <= 1'b1;
                        end
                    endcase
                end
                ST_LOAD: begin
                    if (s_valid && cnt_one) begin
                        state_q    <= ST_GAP;
                        job_done_q <= 1'b1;
                        s_ready_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (core_done || cnt_one || cnt_zero) begin
                        state_q    <= ST_GAP;
                        job_done_q <= 1'b1;
                        if (!core_done) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cnt_one || cnt_zero) begin
                        state_q     <= ST_GAP;
                        job_done_q  <= 1'b1;
                        drain_vld_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Load words pass straight through to the core in the handshake cycle.
    assign load_hs        = s_ready_q && s_valid;
    assign cmd_ready      = cmd_ready_q;
    assign s_ready        = s_ready_q;
    assign core_op_code   = op_code_q;
    assign core_din_valid = drain_vld_q || load_hs;
    assign core_din0      = load_hs ? s_data : '0;
    assign busy           = busy_q;
    assign job_done       = job_done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_ntt_cmd_sequencer.sv
// Directed, table-driven bench for ntt_cmd_sequencer plus hand sequences for
// back-to-back jobs and reset in the middle of a load.
module tb_ntt_cmd_sequencer;
    import ntt_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [3:0]  cfg_ring_depth;
    logic [12:0] cfg_tw_words;
    logic [11:0] cfg_drain_len;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [4:0]  core_op_code;
    logic        core_din_valid;
    logic [31:0] core_din0;
    logic        core_done;
    logic        busy;
    logic        job_done;
    logic        err;

    always #5 clk = ~clk;

    ntt_cmd_sequencer #(
        .DATA_W(32), .OPC_W(5), .MAX_DEPTH(12), .POLY_CNT(2),
        .TW_W(13), .DRAIN_W(12), .TIMEOUT(1000)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cfg_ring_depth(cfg_ring_depth), .cfg_tw_words(cfg_tw_words),
        .cfg_drain_len(cfg_drain_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_op_code(core_op_code), .core_din_valid(core_din_valid),
        .core_din0(core_din0), .core_done(core_done),
        .busy(busy), .job_done(job_done), .err(err)
    );

    typedef struct {
        logic [4:0] op;
        int depth;
        int tw;
        int drain;
        int gap_n;
        int done_at;
        int exp_valid;
        int exp_words;
        int exp_jd;
        int exp_err;
        int exp_ops;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    int tests = 0;
    int fails = 0;

    int rel, vcnt, opcnt, op_rel, jdcnt, jd_rel, ord_err, inv_err, srdy_cnt;
    int src_idx, exp_idx, gap_n, done_at;
    bit src_en, param_mode, load_mon;
    logic [4:0]  last_op;
    logic        smp_cmd_ready, smp_busy, smp_err, smp_valid, smp_s_ready, smp_jd;
    logic [4:0]  smp_op;
    logic [31:0] smp_din0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_word(input int i, input bit pm);
        if (pm && i == 0) return 32'h0000_0001;
        if (pm && i == 1) return 32'h0000_3C01;
        if (pm && i == 2) return 32'h0000_3BE1;
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // One clock: sample at negedge, drive the next cycle's inputs 1 after posedge.
    task automatic cycle();
        bit hs;
        @(negedge clk);
        smp_cmd_ready = cmd_ready;
        smp_busy      = busy;
        smp_err       = err;
        smp_valid     = core_din_valid;
        smp_s_ready   = s_ready;
        smp_jd        = job_done;
        smp_op        = core_op_code;
        smp_din0      = core_din0;
        if (core_din_valid) begin
            vcnt++;
            if (load_mon) begin
                if (core_din0 !== src_word(exp_idx, param_mode)) ord_err++;
                exp_idx++;
            end
        end else if (core_din0 != 32'h0) begin
            inv_err++;
        end
        if (core_op_code != 5'h0) begin
            opcnt++;
            op_rel  = rel;
            last_op = core_op_code;
        end
        if (job_done) begin
            if (jdcnt == 0) jd_rel = rel;
            jdcnt++;
        end
        if (s_ready) srdy_cnt++;
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) src_idx++;
        rel++;
        s_valid   = src_en && !(gap_n != 0 && (rel % gap_n) == gap_n - 1);
        s_data    = src_word(src_idx, param_mode);
        core_done = (done_at >= 0) && (rel >= done_at);
    endtask

    task automatic clear_mon();
        vcnt = 0; opcnt = 0; op_rel = -1; jdcnt = 0; jd_rel = -1;
        ord_err = 0; inv_err = 0; srdy_cnt = 0; src_idx = 0; exp_idx = 0;
        last_op = 5'h0; rel = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; src_en = 1'b0; s_valid = 1'b0;
        core_done = 1'b0; done_at = -1; gap_n = 0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic run_job(input int k);
        int n;
        bit is_load;
        do_reset();
        clear_mon();
        is_load    = (vecs[k].op == OP_LD_PARAM) || (vecs[k].op == OP_LD_W) ||
                     (vecs[k].op == OP_LD_DATA);
        param_mode = (vecs[k].op == OP_LD_PARAM);
        load_mon   = is_load;
        gap_n      = vecs[k].gap_n;
        src_en     = 1'b1;
        s_valid    = !(gap_n == 1);
        s_data     = src_word(0, param_mode);
        cmd_valid  = 1'b1;
        cmd_op     = vecs[k].op;
        cfg_ring_depth = 4'(vecs[k].depth);
        cfg_tw_words   = 13'(vecs[k].tw);
        cfg_drain_len  = 12'(vecs[k].drain);
        rel = 0;
        cycle();
        cmd_valid = 1'b0;
        done_at   = vecs[k].done_at;
        n = 0;
        while (jdcnt == 0 && n < 3000) begin
            cycle();
            n++;
        end
        cycle();
        check($sformatf("v%0d job_done pulses", k), jdcnt, 1);
        check($sformatf("v%0d cmd_ready after", k), int'(smp_cmd_ready), 1);
        check($sformatf("v%0d busy after", k), int'(smp_busy), 0);
        check($sformatf("v%0d din_valid count", k), vcnt, vecs[k].exp_valid);
        check($sformatf("v%0d words consumed", k), src_idx, vecs[k].exp_words);
        check($sformatf("v%0d err", k), int'(smp_err), vecs[k].exp_err);
        check($sformatf("v%0d opcode cycles", k), opcnt, vecs[k].exp_ops);
        check($sformatf("v%0d din0 nonzero when idle", k), inv_err, 0);
        if (vecs[k].exp_ops > 0)
            check($sformatf("v%0d opcode value", k), int'(last_op), int'(vecs[k].op));
        if (vecs[k].exp_jd >= 0)
            check($sformatf("v%0d job_done cycle", k), jd_rel, vecs[k].exp_jd);
        if (is_load)
            check($sformatf("v%0d word order errors", k), ord_err, 0);
        else
            check($sformatf("v%0d s_ready cycles", k), srdy_cnt, 0);
        $display("[TB] vector %0d op=%02h valid=%0d words=%0d jd@%0d err=%0d",
                 k, vecs[k].op, vcnt, src_idx, jd_rel, smp_err);
    endtask

    initial begin
        int n;
        int vsave;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 5'h0; cfg_ring_depth = 4'h0;
        cfg_tw_words = '0; cfg_drain_len = '0; s_valid = 1'b0; s_data = '0;
        core_done = 1'b0; src_en = 1'b0; param_mode = 1'b0; load_mon = 1'b0;
        done_at = -1; gap_n = 0;
        clear_mon();

        //            op           dep tw drain gap done  valid words jd    err ops
        vecs[0]  = '{OP_LD_PARAM, 0,  0,  0,   0,  -1,   3,    3,    5,    0,  1};
        vecs[1]  = '{OP_LD_W,     0,  5,  0,   2,  -1,   5,    5,    11,   0,  1};
        vecs[2]  = '{OP_LD_W,     0,  0,  0,   0,  -1,   0,    0,    2,    0,  1};
        vecs[3]  = '{OP_LD_DATA,  9,  0,  0,   4,  -1,   1024, 1024, 1367, 0,  1};
        vecs[4]  = '{OP_LD_DATA,  2,  0,  0,   0,  -1,   8,    8,    10,   0,  1};
        vecs[5]  = '{OP_NTT,      0,  0,  0,   0,  300,  0,    0,    301,  0,  1};
        vecs[6]  = '{OP_INTT,     0,  0,  0,   0,  2,    0,    0,    3,    0,  1};
        vecs[7]  = '{OP_PWM,      0,  0,  0,   0,  -1,   0,    0,    1002, 1,  1};
        vecs[8]  = '{OP_READ,     0,  0,  74,  0,  -1,   74,   0,    75,   0,  1};
        vecs[9]  = '{OP_READ_INV, 0,  0,  1,   0,  -1,   1,    0,    2,    0,  1};
        vecs[10] = '{OP_READ,     0,  0,  0,   0,  -1,   1,    0,    2,    0,  1};
        vecs[11] = '{OP_READ,     0,  0,  2,   0,  -1,   2,    0,    3,    0,  1};
        vecs[12] = '{5'h1F,       0,  0,  0,   0,  -1,   0,    0,    1,    1,  0};
        vecs[13] = '{5'h00,       0,  0,  0,   0,  -1,   0,    0,    1,    1,  0};

        do_reset();
        check("reset cmd_ready", int'(smp_cmd_ready), 1);
        check("reset busy", int'(smp_busy), 0);
        check("reset din_valid", int'(smp_valid), 0);
        check("reset s_ready", int'(smp_s_ready), 0);
        check("reset op_code", int'(smp_op), 0);
        check("reset job_done", int'(smp_jd), 0);
        check("reset err", int'(smp_err), 0);
        $display("[TB] reset state checked");

        for (int k = 0; k < NVEC; k++) run_job(k);

        // Back-to-back LOAD_PARAM jobs with cmd_valid held high.
        do_reset();
        clear_mon();
        param_mode = 1'b1; load_mon = 1'b0; gap_n = 0; src_en = 1'b1;
        s_valid = 1'b1; s_data = src_word(0, 1'b1);
        cmd_valid = 1'b1; cmd_op = OP_LD_PARAM;
        n = 0;
        while (opcnt < 2 && n < 50) begin
            cycle();
            n++;
        end
        cmd_valid = 1'b0;
        check("b2b second opcode cycle", op_rel, 7);
        n = 0;
        while (jdcnt < 2 && n < 50) begin
            cycle();
            n++;
        end
        check("b2b second job_done cycle", jd_rel >= 0 ? rel - 1 : -1, 11);
        check("b2b din_valid count", vcnt, 6);
        check("b2b words consumed", src_idx, 6);
        $display("[TB] back-to-back: op2@%0d valid=%0d words=%0d", op_rel, vcnt, src_idx);

        // Illegal job sets err; a reset in the middle of a long load clears it.
        do_reset();
        clear_mon();
        cmd_valid = 1'b1; cmd_op = 5'h1F;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        check("illegal err", int'(smp_err), 1);
        check("illegal opcode cycles", opcnt, 0);
        clear_mon();
        param_mode = 1'b0; load_mon = 1'b1; gap_n = 0; src_en = 1'b1;
        s_valid = 1'b1; s_data = src_word(0, 1'b0);
        cmd_valid = 1'b1; cmd_op = OP_LD_W; cfg_tw_words = 13'd1272;
        cycle();
        cmd_valid = 1'b0;
        n = 0;
        while (src_idx < 99 && n < 500) begin
            cycle();
            n++;
        end
        check("err sticky during load", int'(smp_err), 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("midreset din_valid", int'(smp_valid), 0);
        check("midreset s_ready", int'(smp_s_ready), 0);
        check("midreset op_code", int'(smp_op), 0);
        check("midreset job_done", int'(smp_jd), 0);
        check("midreset busy", int'(smp_busy), 0);
        check("midreset cmd_ready", int'(smp_cmd_ready), 1);
        check("midreset err", int'(smp_err), 0);
        check("midreset din0", int'(smp_din0), 0);
        vsave = vcnt;
        repeat (20) cycle();
        check("midreset words consumed", src_idx, 100);
        check("midreset valid before reset", vsave, 100);
        check("midreset no words after", vcnt, vsave);
        check("midreset order errors", ord_err, 0);
        $display("[TB] mid-load reset: words=%0d valid=%0d", src_idx, vcnt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ntt_cmd_sequencer.md
Name: ntt_cmd_sequencer

Overview:
- Hardware command sequencer in front of the parametrised NTT core (NTT1024 family).
- Replaces hand-timed OP_CODE/din_valid/din0 driving with a job-level interface: accepts one job (core opcode), generates the opcode pulse, streams the correct number of words from a valid/ready source, then waits for core completion or runs a drain window.
- Generalises the single-lane, fixed-size flow to any ring depth, PE depth and polynomial count, and adds timeout/error reporting.

Parameters:
- DATA_W, 32, core data word width
- OPC_W, 5, core opcode width
- MAX_DEPTH, 12, maximum ring depth supported (sets counter widths)
- POLY_CNT, 2, polynomials per LOAD_DATA job
- TW_W, 13, width of the twiddle word-count configuration
- DRAIN_W, 12, width of the drain-length configuration
- TIMEOUT, 65535, maximum cycles to wait for core_done

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  sequencer idle, job accepted when cmd_valid&cmd_ready
- cmd_op  in  OPC_W  core opcode of job
- cfg_ring_depth  in  4  log2 ring size, sampled at accept
- cfg_tw_words  in  TW_W  twiddle word count, sampled at accept
- cfg_drain_len  in  DRAIN_W  drain cycles, sampled at accept
- s_valid  in  1  source word valid
- s_data  in  DATA_W  source word
- s_ready  out  1  source word consumed when s_valid&s_ready
- core_op_code  out  OPC_W  to core OP_CODE
- core_din_valid  out  1  to core din_valid
- core_din0  out  DATA_W  to core din0
- core_done  in  1  core done level
- busy  out  1  not IDLE
- job_done  out  1  one-cycle pulse at job completion
- err  out  1  sticky timeout/illegal-op flag

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE; counters 0; err cleared. A reset mid-job abandons it; no further opcode or words are issued.
- Job classes by cmd_op:
  - LOAD: 00001 loads 3 words; 00010 loads cfg_tw_words words; 00011 loads POLY_CNT<<cfg_ring_depth words.
  - COMPUTE: 00100, 00111, 01010; waits for core_done.
  - DRAIN: 01000, 01011; din_valid held high for cfg_drain_len cycles.
  - Any other opcode is illegal: set err, pulse job_done, stay IDLE.
- States: IDLE -> ISSUE -> (LOAD | WAIT | DRAIN) -> GAP -> IDLE.
- ISSUE, 1 cycle: core_op_code=cmd_op for exactly one cycle. core_din_valid is 0, except for DRAIN jobs, where it is 1.
- LOAD:
  - s_ready=1.
  - Each source handshake drives core_din_valid=1 and core_din0=s_data in the same cycle (combinational pass, zero latency).
  - s_valid low gives core_din_valid=0; the core ignores such cycles.
  - Leave LOAD after the final counted word; count 0 goes straight to GAP.
- WAIT:
  - Complete on the cycle core_done is first seen 1 (level, not edge).
  - The timeout counter counts cycles spent in WAIT. When it reaches TIMEOUT with no core_done: set err, then go to GAP.
- DRAIN: core_din_valid=1 for cfg_drain_len cycles total, counting the ISSUE cycle. Length 0 or 1 goes to GAP after ISSUE.
- GAP: 1 idle cycle with core_din_valid=0 and core_op_code=0; job_done pulses here. Guarantees the core sees an idle cycle between jobs.
- cmd_ready=1 only in IDLE. A job issued on the cycle after GAP is legal (back-to-back jobs, min 1 idle cycle between).
- s_ready=0 outside LOAD; source words are never dropped or duplicated.
- core_din0 is 0 whenever core_din_valid=0.
- err clears only on reset.
- Word counter width: MAX_DEPTH+clog2(POLY_CNT)+1, with no wrap at max configuration.

Decomposition:
- Shared package ntt_pkg holds:
  - opcode constants OP_LD_PARAM=00001, OP_LD_W=00010, OP_LD_DATA=00011, OP_NTT=00100, OP_INTT=00111, OP_READ_INV=01000, OP_PWM=01010, OP_READ=01011;
  - the state enum;
  - the PARAM_WORDS=3 constant.
- One natural sub-module, ntt_seq_counter: a loadable down-counter with zero flag, reused for the word, drain and timeout counts.

Test Plan:
- LOAD_PARAM: job 00001, source words 1, 3C01, 3BE1 back-to-back -> opcode pulse 1 cycle; din_valid on 3 consecutive cycles with those words; then 1 GAP cycle; job_done pulses; cmd_ready returns 1.
- LOAD_DATA with gaps: ring_depth=9, POLY_CNT=2, s_valid deasserted every 4th cycle -> exactly 1024 din_valid cycles in source order; s_ready drops after word 1024; the 1025th word is not consumed.
- COMPUTE: job 00100, core_done asserted 300 cycles later -> job_done pulses 1 cycle after done is seen; err=0. Repeat with done never asserted and TIMEOUT=1000 -> err=1 after 1000 WAIT cycles; sequencer returns to IDLE.
- DRAIN: job 01011, cfg_drain_len=74 -> din_valid high for exactly 74 cycles including the opcode cycle; s_ready stays 0 throughout.
- Illegal and reset: job 11111 -> err=1, no opcode issued. Reset asserted on the 100th word of a 1272-word LOAD_W -> next cycle all outputs 0, cmd_ready=1, err=0.
